ps2_host_port: RTL and testbench

Parametrised bidirectional PS/2 host port that replaces the receive-only front end of the PET keyboard path. Filters the PS/2 clock and data lines and deframes device-to-host bytes into a show-ahead FIFO, reporting parity, framing and timeout errors. Also transmits host-to-device command bytes, such as LED set 8'hED, through open-drain enables. Sits between the board PS/2 pads and the scan-code-to-PET-matrix translator.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_port.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_host_port.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host port: controller states, error codes
// and the odd-parity helper used on both the receive and transmit paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RX         = 3'd1,
    S_TX_INHIBIT = 3'd2,
    S_TX_START   = 3'd3,
    S_TX_BITS    = 3'd4,
    S_TX_ACK     = 3'd5,
    S_TX_RELEASE = 3'd6
  } state_t;

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAME   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus a run-length glitch filter for one PS/2 line.
// o_edge pulses for one cycle, the cycle after o_level changes.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_edge
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_filt;
  logic          r_filt_d;
  logic [CW-1:0] r_cnt;

  // Lines idle high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_s1     <= i_line;
      r_s2     <= r_s1;
      r_filt_d <= r_filt;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_filt;
  assign o_edge  = r_filt ^ r_filt_d;

endmodule

// File: rtl/ps2_host_port.sv
// Bidirectional PS/2 host port: deframes device bytes into a show-ahead FIFO
// and sends host command bytes through open-drain clock/data enables.
module ps2_host_port
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       fifo_ovf,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_nack,
  output logic [2:0] dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic w_clk_lvl, w_clk_edge, w_clk_fall;
  logic w_data_lvl, w_data_edge_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .reset   (reset),
    .i_line  (ps2_clk),
    .o_level (w_clk_lvl),
    .o_edge  (w_clk_edge)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .reset   (reset),
    .i_line  (ps2_data),
    .o_level (w_data_lvl),
    .o_edge  (w_data_edge_unused)
  );

  assign w_clk_fall = w_clk_edge & ~w_clk_lvl;

  state_t        r_state, w_nxt_state;
  logic [3:0]    r_cnt, w_nxt_cnt;
  logic [7:0]    r_shift, w_nxt_shift;
  logic          r_par, w_nxt_par;
  logic          r_start, w_nxt_start;
  logic [IW-1:0] r_inh, w_nxt_inh;
  logic [TW-1:0] r_to, w_nxt_to;
  logic          r_clk_oe, w_nxt_clk_oe;
  logic          r_data_oe, w_nxt_data_oe;
  logic          r_rx_err, r_ovf, r_tx_done, r_tx_nack;
  logic [1:0]    r_err_code, w_nxt_err_code;
  logic          w_err, w_done, w_nack, w_push_req, w_timeout, w_to_run, w_is_tx;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_push, w_pop, w_ovf;

  // Both rx and tx use valid/ready: a transfer happens on a clock edge where
  // valid and ready are both high; valid must not depend on ready.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop    = rx_ready && !w_empty;
  assign w_push   = w_push_req && (!w_full || w_pop);
  assign w_ovf    = w_push_req && w_full && !w_pop;

  assign w_to_run = (r_state != S_IDLE) && (r_state != S_TX_INHIBIT);
  assign w_is_tx  = (r_state == S_TX_START) || (r_state == S_TX_BITS) ||
                    (r_state == S_TX_ACK);
  assign w_timeout = w_to_run && !w_clk_edge && (r_to == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cnt      = r_cnt;
    w_nxt_shift    = r_shift;
    w_nxt_par      = r_par;
    w_nxt_start    = r_start;
    w_nxt_inh      = '0;
    w_nxt_clk_oe   = r_clk_oe;
    w_nxt_data_oe  = r_data_oe;
    w_nxt_err_code = r_err_code;
    w_err          = 1'b0;
    w_done         = 1'b0;
    w_nack         = 1'b0;
    w_push_req     = 1'b0;
    w_nxt_to       = (!w_to_run || w_clk_edge) ? '0 : r_to + TW'(1);
    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_nxt_state  = S_TX_INHIBIT;
          w_nxt_shift  = tx_data;
          w_nxt_par    = odd_parity(tx_data);
          w_nxt_clk_oe = 1'b1;
        end else if (w_clk_fall) begin
          w_nxt_state = S_RX;
          w_nxt_start = w_data_lvl;
          w_nxt_cnt   = 4'd1;
        end
      end
      S_RX: begin
        if (w_clk_fall) begin
          w_nxt_cnt = r_cnt + 4'd1;
          if (r_cnt <= 4'd8) begin
            w_nxt_shift = {w_data_lvl, r_shift[7:1]};
          end else if (r_cnt == 4'd9) begin
            w_nxt_par = w_data_lvl;
          end else if (r_cnt == 4'(FRAME_BITS - 1)) begin
            w_nxt_state = S_IDLE;
            if (r_start || !w_data_lvl) begin
              w_err          = 1'b1;
              w_nxt_err_code = ERR_FRAME;
            end else if (!(^{r_shift, r_par})) begin
              w_err          = 1'b1;
              w_nxt_err_code = ERR_PARITY;
            end else begin
              w_push_req = 1'b1;
            end
          end
        end
      end
      S_TX_INHIBIT: begin
        if (r_inh == IW'(INHIBIT_CYC - 1)) begin
          w_nxt_state   = S_TX_START;
          w_nxt_data_oe = 1'b1;
        end else begin
          w_nxt_inh = r_inh + IW'(1);
        end
      end
      S_TX_START: begin
        w_nxt_state  = S_TX_BITS;
        w_nxt_clk_oe = 1'b0;
        w_nxt_cnt    = 4'd0;
      end
      S_TX_BITS: begin
        if (w_clk_fall) begin
          w_nxt_cnt = r_cnt + 4'd1;
          if (r_cnt <= 4'd7) begin
            w_nxt_data_oe = ~r_shift[r_cnt[2:0]];
          end else if (r_cnt == 4'd8) begin
            w_nxt_data_oe = ~r_par;
          end else begin
            w_nxt_data_oe = 1'b0;
            w_nxt_state   = S_TX_ACK;
          end
        end
      end
      S_TX_ACK: begin
        if (w_clk_fall) begin
          w_nxt_state = S_TX_RELEASE;
          w_done      = !w_data_lvl;
          w_nack      = w_data_lvl;
        end
      end
      S_TX_RELEASE: begin
        if (w_clk_lvl && w_data_lvl) w_nxt_state = S_IDLE;
      end
      default: w_nxt_state = S_IDLE;
    endcase
    // A stalled bus overrides whatever the state was doing this cycle.
    if (w_timeout) begin
      w_nxt_state    = S_TX_RELEASE;
      w_nxt_clk_oe   = 1'b0;
      w_nxt_data_oe  = 1'b0;
      w_err          = 1'b1;
      w_nxt_err_code = ERR_TIMEOUT;
      w_nack         = w_is_tx;
      w_done         = 1'b0;
      w_push_req     = 1'b0;
      w_nxt_to       = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_start    <= 1'b0;
      r_inh      <= '0;
      r_to       <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_rx_err   <= 1'b0;
      r_err_code <= 2'b00;
      r_ovf      <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_nack  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_shift    <= w_nxt_shift;
      r_par      <= w_nxt_par;
      r_start    <= w_nxt_start;
      r_inh      <= w_nxt_inh;
      r_to       <= w_nxt_to;
      r_clk_oe   <= w_nxt_clk_oe;
      r_data_oe  <= w_nxt_data_oe;
      r_rx_err   <= w_err;
      r_err_code <= w_nxt_err_code;
      r_ovf      <= w_ovf;
      r_tx_done  <= w_done;
      r_tx_nack  <= w_nack;
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign rx_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign rx_valid    = !w_empty;
  assign rx_err      = r_rx_err;
  assign err_code    = r_err_code;
  assign fifo_ovf    = r_ovf;
  assign tx_ready    = (r_state == S_IDLE);
  assign tx_done     = r_tx_done;
  assign tx_nack     = r_tx_nack;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_host_port.sv
// Scoreboard bench for ps2_host_port: a PS/2 device model drives the pads,
// expected bytes/errors/tx results are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_ps2_host_port;
  import ps2_pkg::*;

  localparam int FL  = 8;
  localparam int FD  = 8;
  localparam int INH = 200;
  localparam int TO  = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_data;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_err, fifo_ovf;
  logic [1:0] err_code;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_done, tx_nack;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  logic [1:0] err_q[$];
  logic [1:0] txr_q[$];
  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;

  // Open-drain pads: either side may pull low.
  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  ps2_host_port #(
    .FILTER_LEN(FL), .FIFO_DEPTH(FD), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_err(rx_err), .err_code(err_code), .fifo_ovf(fifo_ovf),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_nack(tx_nack), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                           input logic stop);
    return {stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
        end else chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
      end
      if (rx_err) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_unexpected actual=%0h required=none", err_code);
        end else chk("err_code", int'(err_code), int'(err_q.pop_front()));
      end
      if (fifo_ovf) ovf_cnt++;
      if (tx_done || tx_nack) begin
        if (txr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%0h required=none", {tx_done, tx_nack});
        end else chk("tx_result", int'({tx_done, tx_nack}), int'(txr_q.pop_front()));
      end
    end
  end

  task automatic send_bits(input logic [10:0] f, input int nbits, input bit measure);
    int n;
    for (int i = 0; i < nbits; i++) begin
      dev_data = f[i];
      wait_cyc(10);
      dev_clk = 1'b0;
      if (measure && i == FRAME_BITS - 1) begin
        n = 0;
        while (!rx_valid && n < 40) begin
          @(posedge clk); #1; n++;
        end
        chk("rx_valid_latency", n, FL + 3);
      end
      wait_cyc(30);
      dev_clk = 1'b1;
      wait_cyc(30);
    end
    dev_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic dev_tx(input int nclk, input logic ack_bit, output logic [9:0] got);
    int n = 0;
    got = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < INH + 100) begin
      @(posedge clk); #1; n++;
    end
    chk("tx_request_seen", int'(ps2_data_oe && !ps2_clk_oe), 1);
    wait_cyc(20);
    for (int i = 0; i < nclk && i < 10; i++) begin
      dev_clk = 1'b0;
      wait_cyc(30);
      got[i] = ps2_data;
      dev_clk = 1'b1;
      wait_cyc(30);
    end
    if (nclk > 10) begin
      dev_data = ack_bit;
      wait_cyc(10);
      dev_clk = 1'b0;
      wait_cyc(30);
      dev_clk = 1'b1;
      wait_cyc(30);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() + err_q.size() + txr_q.size()) != 0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk(name, exp_q.size() + err_q.size() + txr_q.size(), 0);
  endtask

  task automatic wait_tx_idle(input string name);
    int n = 0;
    while (!tx_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk(name, int'(tx_ready), 1);
  endtask

  initial begin
    int n;
    logic [9:0] got;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    reset    = 1'b1;
    wait_cyc(5);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_err", int'(rx_err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_fifo_ovf", int'(fifo_ovf), 0);
    chk("rst_tx_ready", int'(tx_ready), 1);
    chk("rst_tx_done", int'(tx_done), 0);
    chk("rst_tx_nack", int'(tx_nack), 0);
    chk("rst_state", int'(dbg_state), 0);
    reset = 1'b0;
    wait_cyc(5);

    // Good byte stream, consumer always ready.
    rx_ready = 1'b1;
    exp_q.push_back(8'h1A); send_bits(mk_frame(8'h1A, 1'b0, 1'b1), 11, 1'b1);
    exp_q.push_back(8'hF0); send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 11, 1'b0);
    exp_q.push_back(8'h1A); send_bits(mk_frame(8'h1A, 1'b0, 1'b1), 11, 1'b0);
    wait_drained("rx_stream", 50);

    // Parity and framing errors discard the byte.
    err_q.push_back(ERR_PARITY);
    send_bits(mk_frame(8'h1A, 1'b1, 1'b1), 11, 1'b0);
    wait_drained("parity_err", 50);
    chk("parity_no_push", int'(rx_valid), 0);
    chk("parity_code_held", int'(err_code), int'(ERR_PARITY));
    err_q.push_back(ERR_FRAME);
    send_bits(mk_frame(8'h1A, 1'b0, 1'b0), 11, 1'b0);
    wait_drained("frame_err", 50);
    chk("frame_no_push", int'(rx_valid), 0);
    chk("frame_code_held", int'(err_code), int'(ERR_FRAME));

    // Nine bytes into an eight-entry FIFO with no consumer.
    rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < FD) exp_q.push_back(8'(i));
      send_bits(mk_frame(8'(i), 1'b0, 1'b1), 11, 1'b0);
    end
    chk("fifo_ovf_pulses", ovf_cnt, 1);
    chk("fifo_full_valid", int'(rx_valid), 1);
    chk("fifo_full_head", int'(rx_data), 0);
    rx_ready = 1'b1;
    wait_drained("fifo_drain", 40);
    wait_cyc(2);
    chk("fifo_empty_after_drain", int'(rx_valid), 0);

    // Host command 8'hED, device acks with 0.
    txr_q.push_back(2'b10);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("tx_ready_falls", int'(tx_ready), 0);
    chk("tx_clk_oe_rises", int'(ps2_clk_oe), 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < INH + 50) begin
      n++; @(posedge clk); #1;
    end
    chk("tx_inhibit_cycles", n, INH);
    chk("tx_start_clk_held", int'(ps2_clk_oe), 1);
    chk("tx_start_data_low", int'(ps2_data_oe), 1);
    dev_tx(11, 1'b0, got);
    chk("tx_byte", int'(got[7:0]), 8'hED);
    // ED has six ones, so the odd parity bit is 1.
    chk("tx_parity", int'(got[8]), 1);
    chk("tx_stop", int'(got[9]), 1);
    wait_drained("tx_done", 100);
    wait_tx_idle("tx_ready_back");

    // Device stalls mid-frame while receiving.
    err_q.push_back(ERR_TIMEOUT);
    send_bits(mk_frame(8'h1A, 1'b0, 1'b1), 4, 1'b0);
    wait_drained("rx_timeout", TO + 200);
    chk("rx_to_clk_oe", int'(ps2_clk_oe), 0);
    chk("rx_to_data_oe", int'(ps2_data_oe), 0);
    chk("rx_to_no_push", int'(rx_valid), 0);
    wait_tx_idle("rx_to_idle");

    // Device stalls mid-frame while the host transmits.
    txr_q.push_back(2'b01);
    err_q.push_back(ERR_TIMEOUT);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    dev_tx(4, 1'b0, got);
    chk("tx_to_holding_data", int'(ps2_data_oe), 1);
    wait_drained("tx_timeout", TO + 200);
    chk("tx_to_clk_oe", int'(ps2_clk_oe), 0);
    chk("tx_to_data_oe", int'(ps2_data_oe), 0);
    wait_tx_idle("tx_to_idle");

    // Reset releases the clock line without waiting for a clock edge.
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_cyc(10);
    chk("pre_reset_clk_oe", int'(ps2_clk_oe), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("async_rst_data_oe", int'(ps2_data_oe), 0);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(5);

    // Reset in the middle of a received frame, then a clean byte.
    send_bits(mk_frame(8'h77, 1'b0, 1'b1), 5, 1'b0);
    reset = 1'b1;
    wait_cyc(3);
    chk("mid_rx_reset_state", int'(dbg_state), 0);
    reset = 1'b0;
    wait_cyc(5);
    exp_q.push_back(8'h2C);
    send_bits(mk_frame(8'h2C, 1'b0, 1'b1), 11, 1'b0);
    wait_drained("post_reset_byte", 50);
    chk("post_reset_no_err", int'(err_code), 0);
    wait_cyc(2);
    chk("post_reset_empty", int'(rx_valid), 0);

    chk("ovf_total", ovf_cnt, 1);
    chk("queues_empty", exp_q.size() + err_q.size() + txr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
